// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Each change of tick_in moves the scan to the next common-anode digit.
// Every digit switch is preceded by an all-off blanking interval, which
// suppresses ghosting. Segment, decimal-point and anode outputs are all
// registered, and they stay fixed for the whole time a digit is shown.
module seven_seg_scan_ctrl #(
   parameter int  NUM_DIGITS   = 2,
   parameter int  BLANK_CYCLES = 4,
   localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int CNT_W        = $clog2(BLANK_CYCLES + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick_in,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   anode_out,
   output logic [IDX_W-1:0]        digit_idx
);

   typedef enum logic {
      ST_SHOW  = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   state_t                r_state,      w_state_nxt;
   logic [CNT_W-1:0]      r_blank_cnt,  w_blank_cnt_nxt;
   logic [IDX_W-1:0]      r_digit_idx,  w_digit_idx_nxt;
   logic [6:0]            r_seg,        w_seg_nxt;
   logic                  r_dp,         w_dp_nxt;
   logic [NUM_DIGITS-1:0] r_anode,      w_anode_nxt;
   logic                  r_tick_prev;

   logic                  w_event;
   logic [IDX_W-1:0]      w_idx_inc;
   logic [3:0]            w_new_nibble;
   logic                  w_new_dp;
   logic [NUM_DIGITS-1:0] w_new_anode;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    return 7'h40;
         4'h1:    return 7'h79;
         4'h2:    return 7'h24;
         4'h3:    return 7'h30;
         4'h4:    return 7'h19;
         4'h5:    return 7'h12;
         4'h6:    return 7'h02;
         4'h7:    return 7'h78;
         4'h8:    return 7'h00;
         4'h9:    return 7'h10;
         4'hA:    return 7'h08;
         4'hB:    return 7'h03;
         4'hC:    return 7'h46;
         4'hD:    return 7'h21;
         4'hE:    return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   // A scan event is any change of the divider toggle, rising or falling.
   assign w_event = tick_in ^ r_tick_prev;

   // The index that comes next wraps at the last digit, so unused codes
   // are never reached when NUM_DIGITS is not a power of two.
   assign w_idx_inc = (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                               : r_digit_idx + IDX_W'(1);

   // Select the nibble, dp request and anode pattern of the upcoming digit.
   always_comb begin
      w_new_nibble = '0;
      w_new_dp     = 1'b0;
      w_new_anode  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_idx_inc == IDX_W'(i)) begin
            w_new_nibble   = digits_in[4*i +: 4];
            w_new_dp       = dp_in[i];
            w_new_anode[i] = 1'b0;
         end
      end
   end

   // Next-state and next-output logic for the SHOW/BLANK scan.
   always_comb begin
      // NOTE: every signal gets a default before any branch. Without these
      //       defaults, a path that skips an assignment infers a latch.
      w_state_nxt     = r_state;
      w_blank_cnt_nxt = r_blank_cnt;
      w_digit_idx_nxt = r_digit_idx;
      w_seg_nxt       = r_seg;
      w_dp_nxt        = r_dp;
      w_anode_nxt     = r_anode;

      case (r_state)
         ST_SHOW: begin
            if (w_event) begin
               w_state_nxt     = ST_BLANK;
               w_blank_cnt_nxt = CNT_W'(BLANK_CYCLES);
               w_anode_nxt     = '1;
               w_seg_nxt       = 7'h7F;
               w_dp_nxt        = 1'b1;
            end
         end
         ST_BLANK: begin
            // Events that arrive while blanking are dropped on purpose.
            if (r_blank_cnt <= CNT_W'(1)) begin
               w_state_nxt     = ST_SHOW;
               w_digit_idx_nxt = w_idx_inc;
               w_seg_nxt       = hex_to_seg(w_new_nibble);
               w_dp_nxt        = ~w_new_dp;
               w_anode_nxt     = w_new_anode;
            end else begin
               w_blank_cnt_nxt = r_blank_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_BLANK;
         end
      endcase
   end

   // State, snapshot and output registers. Reset takes priority over events.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      //       then sample the values from before the edge, which avoids races
      //       between processes.
      r_tick_prev <= tick_in;
      if (reset) begin
         r_state     <= ST_BLANK;
         r_blank_cnt <= CNT_W'(BLANK_CYCLES);
         r_digit_idx <= IDX_W'(NUM_DIGITS - 1);
         r_seg       <= 7'h7F;
         r_dp        <= 1'b1;
         r_anode     <= '1;
      end else begin
         r_state     <= w_state_nxt;
         r_blank_cnt <= w_blank_cnt_nxt;
         r_digit_idx <= w_digit_idx_nxt;
         r_seg       <= w_seg_nxt;
         r_dp        <= w_dp_nxt;
         r_anode     <= w_anode_nxt;
      end
   end

   assign seg_out   = r_seg;
   assign dp_out    = r_dp;
   assign anode_out = r_anode;
   assign digit_idx = r_digit_idx;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl. It drives two instances from a shared
// clock, reset and tick: u0 (2 digits, 4 blank cycles) and u1 (3 digits,
// 1 blank cycle). A timestamp-based reference model predicts every output
// of both instances on every cycle.
module tb_seven_seg_scan_ctrl;

   logic        clk;
   logic        reset;
   logic        tick_in;

   logic [7:0]  digits0;
   logic [1:0]  dp0_in;
   logic [6:0]  seg0;
   logic        dp0_out;
   logic [1:0]  anode0;
   logic [0:0]  idx0;

   logic [11:0] digits1;
   logic [2:0]  dp1_in;
   logic [6:0]  seg1;
   logic        dp1_out;
   logic [2:0]  anode1;
   logic [1:0]  idx1;

   int n_vec = 0;
   int n_err = 0;

   seven_seg_scan_ctrl #(.NUM_DIGITS(2), .BLANK_CYCLES(4)) u0 (
      .clk       (clk),
      .reset     (reset),
      .tick_in   (tick_in),
      .digits_in (digits0),
      .dp_in     (dp0_in),
      .seg_out   (seg0),
      .dp_out    (dp0_out),
      .anode_out (anode0),
      .digit_idx (idx0)
   );

   seven_seg_scan_ctrl #(.NUM_DIGITS(3), .BLANK_CYCLES(1)) u1 (
      .clk       (clk),
      .reset     (reset),
      .tick_in   (tick_in),
      .digits_in (digits1),
      .dp_in     (dp1_in),
      .seg_out   (seg1),
      .dp_out    (dp1_out),
      .anode_out (anode1),
      .digit_idx (idx1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decode table, written out from the display character set.
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // For each instance the model tracks whether it is blanking, the
   // absolute cycle at which the next digit appears, the shown index and
   // the latched segment/dp values.
   int         m_nd  [2] = '{2, 3};
   int         m_blk [2] = '{4, 1};
   bit         m_blank   [2];
   int         m_show_at [2];
   int         m_idx     [2];
   logic [6:0] m_seg     [2];
   logic       m_dp      [2];
   logic       m_prev;
   int         m_cyc   = 0;
   bit         m_valid = 0;

   function automatic logic [3:0] get_nib(input int n, input int i);
      return (n == 0) ? digits0[4*i +: 4] : digits1[4*i +: 4];
   endfunction

   function automatic logic get_dp(input int n, input int i);
      return (n == 0) ? dp0_in[i] : dp1_in[i];
   endfunction

   task automatic model_step();
      for (int n = 0; n < 2; n++) begin
         if (reset) begin
            m_blank[n]   = 1'b1;
            m_show_at[n] = m_cyc + m_blk[n];
            m_idx[n]     = m_nd[n] - 1;
         end else if (m_blank[n]) begin
            if (m_cyc == m_show_at[n]) begin
               m_idx[n]   = (m_idx[n] + 1) % m_nd[n];
               m_seg[n]   = seg_tab[get_nib(n, m_idx[n])];
               m_dp[n]    = ~get_dp(n, m_idx[n]);
               m_blank[n] = 1'b0;
            end
         end else if (tick_in != m_prev) begin
            m_blank[n]   = 1'b1;
            m_show_at[n] = m_cyc + m_blk[n];
         end
      end
      m_prev  = tick_in;
      m_cyc++;
      m_valid = 1'b1;
   endtask

   task automatic compare_all();
      int         all_off;
      logic [31:0] exp_an, exp_seg, exp_dp;
      logic [31:0] act_an, act_seg, act_dp, act_idx;
      for (int n = 0; n < 2; n++) begin
         all_off = (1 << m_nd[n]) - 1;
         exp_an  = m_blank[n] ? 32'(all_off) : 32'(all_off & ~(1 << m_idx[n]));
         exp_seg = m_blank[n] ? 32'h7F : 32'(m_seg[n]);
         exp_dp  = m_blank[n] ? 32'h1  : 32'(m_dp[n]);
         act_an  = (n == 0) ? 32'(anode0)  : 32'(anode1);
         act_seg = (n == 0) ? 32'(seg0)    : 32'(seg1);
         act_dp  = (n == 0) ? 32'(dp0_out) : 32'(dp1_out);
         act_idx = (n == 0) ? 32'(idx0)    : 32'(idx1);
         check($sformatf("u%0d anode", n), act_an,  exp_an);
         check($sformatf("u%0d seg",   n), act_seg, exp_seg);
         check($sformatf("u%0d dp",    n), act_dp,  exp_dp);
         check($sformatf("u%0d idx",   n), act_idx, 32'(m_idx[n]));
      end
   endtask

   // Single compare process: update the model on the active edge, then
   // check the registered outputs on the opposite edge.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (m_valid) compare_all();
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scan();
      tick_in = ~tick_in;
      cycles(6);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " u0 anode"}, 32'(anode0), 32'h3);
      check({tag, " u0 seg"},   32'(seg0),   32'h7F);
      check({tag, " u0 dp"},    32'(dp0_out), 32'h1);
      check({tag, " u0 idx"},   32'(idx0),   32'h1);
      check({tag, " u1 anode"}, 32'(anode1), 32'h7);
      check({tag, " u1 idx"},   32'(idx1),   32'h2);
   endtask

   int exp_seq [6] = '{1, 2, 0, 1, 2, 0};

   initial begin
      reset   = 1'b1;
      tick_in = 1'b1;
      digits0 = 8'hA3;
      dp0_in  = 2'b10;
      digits1 = 12'h5C7;
      dp1_in  = 3'b001;
      cycles(3);
      check_reset_vals("reset");
      reset = 1'b0;

      // Blanking after release, then digit 0; tick held at 1 gives no event.
      cycles(1);
      check("u1 first show anode", 32'(anode1), 32'h6);
      check("u1 first show seg",   32'(seg1),   32'h78);
      check("u1 first show dp",    32'(dp1_out), 32'h0);
      check("u0 post-reset blank", 32'(anode0), 32'h3);
      for (int i = 0; i < 2; i++) begin
         cycles(1);
         check("u0 post-reset blank", 32'(anode0), 32'h3);
      end
      cycles(1);
      check("u0 digit0 anode", 32'(anode0), 32'h2);
      check("u0 digit0 idx",   32'(idx0),   32'h0);
      check("u0 digit0 seg",   32'(seg0),   32'h30);
      check("u0 digit0 dp",    32'(dp0_out), 32'h1);

      // One toggle: 4 blank cycles, then digit 1 ('A' with dp lit).
      tick_in = ~tick_in;
      for (int i = 0; i < 4; i++) begin
         cycles(1);
         check("u0 blank anode", 32'(anode0), 32'h3);
         check("u0 blank seg",   32'(seg0),   32'h7F);
      end
      cycles(1);
      check("u0 digit1 anode", 32'(anode0), 32'h1);
      check("u0 digit1 seg",   32'(seg0),   32'h08);
      check("u0 digit1 dp",    32'(dp0_out), 32'h0);
      check("u0 digit1 idx",   32'(idx0),   32'h1);

      // Next toggle wraps back to digit 0.
      scan();
      check("u0 wrap anode", 32'(anode0), 32'h2);
      check("u0 wrap seg",   32'(seg0),   32'h30);
      check("u0 wrap dp",    32'(dp0_out), 32'h1);

      // Input change while showing stays hidden until the next entry.
      digits0[3:0] = 4'h8;
      cycles(3);
      check("u0 snapshot hold", 32'(seg0), 32'h30);
      scan();
      scan();
      check("u0 snapshot update", 32'(seg0), 32'h00);

      // Two toggles inside one blanking window advance only once.
      tick_in = ~tick_in;
      cycles(2);
      tick_in = ~tick_in;
      cycles(8);
      check("u0 dropped event idx",   32'(idx0),   32'h1);
      check("u0 dropped event anode", 32'(anode0), 32'h1);
      scan();

      // Nibble sweep on digit 0.
      for (int v = 0; v < 16; v++) begin
         digits0[3:0] = 4'(v);
         scan();
         scan();
         check($sformatf("u0 sweep %0h idx", v), 32'(idx0), 32'h0);
         check($sformatf("u0 sweep %0h seg", v), 32'(seg0), 32'(seg_tab[v]));
      end

      // Three-digit index sequence from a known start.
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(6);
      check("u1 seq start", 32'(idx1), 32'h0);
      for (int k = 0; k < 6; k++) begin
         scan();
         check($sformatf("u1 seq %0d", k), 32'(idx1), 32'(exp_seq[k]));
      end

      // Reset while blanking.
      tick_in = ~tick_in;
      cycles(1);
      reset = 1'b1;
      cycles(1);
      check_reset_vals("mid-blank reset");
      reset = 1'b0;
      cycles(6);

      // Reset and event on the same edge: reset wins.
      tick_in = ~tick_in;
      reset   = 1'b1;
      cycles(1);
      check_reset_vals("reset+event");
      reset = 1'b0;
      cycles(1);
      check("u1 no spurious event", 32'(anode1), 32'h6);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) tick_in = ~tick_in;
         if ($urandom_range(0, 7) == 0) begin
            digits0 = 8'($urandom);
            digits1 = 12'($urandom);
            dp0_in  = 2'($urandom);
            dp1_in  = 3'($urandom);
         end
         reset = ($urandom_range(0, 249) == 0);
      end
      reset = 1'b0;
      cycles(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
